// File: rtl/rc5_round_scheduler.sv
// rtl/rc5_round_scheduler.sv - RC5 round sequencer with two-channel round-robin job intake
module rc5_round_scheduler #(
  parameter int ROUNDS = 12
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req_vld,
  input  logic [1:0] req_mode,
  output logic [1:0] req_rdy,
  input  logic       key_rdy,
  input  logic       abort,
  output logic       eng_load,
  output logic       eng_step,
  output logic       eng_post,
  output logic       eng_mode,
  output logic [4:0] skey_addr,
  output logic [3:0] round_cnt,
  output logic       res_vld,
  output logic       res_ch,
  input  logic       res_rdy,
  output logic       busy,
  output logic [7:0] jobs_done
);

  typedef enum logic [1:0] {IDLE, ROUND, POST, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_t     state;
  state_t     state_nx;
  logic       ch_q;
  logic       mode_q;
  logic       last_grant;
  logic [3:0] cnt;
  logic [7:0] done_cnt;
  logic       grant;
  logic       g;
  logic       last_step;

  // Round-robin pick: a lone requester wins, a tie goes to the channel not served last
  always_comb begin
    g = 1'b0;
    if (req_vld == 2'b10) begin
      g = 1'b1;
    end else if (req_vld == 2'b11) begin
      g = ~last_grant;
    end
  end

  // Encrypt counts up to ROUNDS, decrypt counts down to 1; gated by clr so reset forces every output low
  assign grant     = clr && (state == IDLE) && key_rdy && !abort && (req_vld != 2'b00);
  assign last_step = mode_q ? (cnt == 4'd1) : (cnt == LAST);

  // Next-state decode; abort outranks every other transition once a job is running
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (grant) state_nx = ROUND;
      ROUND: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (last_step) begin
          state_nx = mode_q ? POST : DONE;
        end
      end
      POST:  state_nx = abort ? IDLE : DONE;
      DONE:  if (abort || res_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, job context and counters; the job's channel and mode are frozen at grant
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      ch_q       <= 1'b0;
      mode_q     <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      done_cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ch_q       <= g;
        mode_q     <= req_mode[g];
        last_grant <= g;
        cnt        <= req_mode[g] ? LAST : 4'd1;
      end else if (state == ROUND) begin
        if (state_nx != ROUND) begin
          cnt <= 4'd0;
        end else begin
          cnt <= mode_q ? cnt - 4'd1 : cnt + 4'd1;
        end
      end
      if ((state == DONE) && res_rdy && !abort) begin
        done_cnt <= done_cnt + 8'd1;
      end
    end
  end

  assign req_rdy   = grant ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign eng_load  = grant;
  assign eng_step  = (state == ROUND);
  assign eng_post  = (state == POST);
  assign eng_mode  = grant ? req_mode[g] : ((state != IDLE) ? mode_q : 1'b0);
  assign skey_addr = (state == ROUND) ? {cnt, 1'b0} : 5'd0;
  assign round_cnt = cnt;
  assign res_vld   = (state == DONE);
  assign res_ch    = (state == DONE) ? ch_q : 1'b0;
  assign busy      = (state != IDLE);
  assign jobs_done = done_cnt;

endmodule
